// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit packer and its payload buffer.
package udp_pkg;

   localparam int CNT_W           = 16;
   localparam int WORD_W          = 32;
   localparam int UDP_MAX_PAYLOAD = 1472;

   typedef enum logic [1:0] {
      FILL,
      DROP,
      START,
      SEND
   } state_t;

endpackage

// File: rtl/udp_tx_buf_ram.sv
// Single-packet payload buffer: one write port and one registered read port.
// rd_data holds its value between reads.
module udp_tx_buf_ram
   import udp_pkg::*;
#(
   parameter int DEPTH = 368,
   parameter int AW    = 9
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/udp_tx_packer.sv
// Packs a framed user byte stream big-endian into 32-bit words and plays the
// packet back one word per tx_req to the UDP transmitter.
module udp_tx_packer
   import udp_pkg::*;
#(
   parameter int MAX_BYTES = UDP_MAX_PAYLOAD,
   parameter int DEPTH     = 368,
   parameter int AW        = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              tx_start_en,
   output logic [CNT_W-1:0]  tx_byte_num,
   output logic [WORD_W-1:0] tx_data,
   input  logic              tx_req,
   input  logic              tx_done,
   output logic              busy,
   output logic              trunc
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   state_t            state;
   logic [CNT_W-1:0]  byte_cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [WORD_W-1:0] pack_q;
   logic [WORD_W-1:0] pack_next;
   logic [WORD_W-1:0] rd_data;
   logic              accept;
   logic              at_max;
   logic              wr_en;
   logic              rd_en;
   logic              rd_zero;

   always_comb begin
      accept   = s_valid && (state == FILL || state == DROP);
      cnt_next = byte_cnt + 1'b1;
      at_max   = (cnt_next == MAX_CNT);
      // A new word starts from zero so unused low lanes of a short tail read as 0.
      pack_next = (byte_cnt[1:0] == 2'd0) ? '0 : pack_q;
      case (byte_cnt[1:0])
         2'd0:    pack_next[31:24] = s_data;
         2'd1:    pack_next[23:16] = s_data;
         2'd2:    pack_next[15:8]  = s_data;
         default: pack_next[7:0]   = s_data;
      endcase
      wr_en = accept && (state == FILL) && (byte_cnt[1:0] == 2'd3 || s_last || at_max);
      rd_en = (state == SEND) && tx_req && !tx_done && (rd_ptr < wr_ptr);
   end

   assign s_ready = (state == FILL) || (state == DROP);
   assign busy    = (state != FILL);
   assign tx_data = rd_zero ? '0 : rd_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= FILL;
         byte_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pack_q      <= '0;
         rd_zero     <= 1'b1;
         tx_start_en <= 1'b0;
         tx_byte_num <= '0;
         trunc       <= 1'b0;
      end else begin
         tx_start_en <= 1'b0;
         trunc       <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  pack_q   <= pack_next;
                  byte_cnt <= cnt_next;
                  if (wr_en)
                     wr_ptr <= wr_ptr + 1'b1;
                  if (s_last)
                     state <= START;
                  else if (at_max) begin
                     trunc <= 1'b1;
                     state <= DROP;
                  end
               end
            end
            DROP: begin
               if (accept && s_last)
                  state <= START;
            end
            START: begin
               tx_start_en <= 1'b1;
               tx_byte_num <= byte_cnt;
               state       <= SEND;
            end
            SEND: begin
               // tx_done takes priority over a same-cycle tx_req.
               if (tx_done) begin
                  state    <= FILL;
                  byte_cnt <= '0;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
               end else if (tx_req) begin
                  if (rd_en) begin
                     rd_ptr  <= rd_ptr + 1'b1;
                     rd_zero <= 1'b0;
                  end else begin
                     rd_zero <= 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   udp_tx_buf_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (pack_next),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_udp_tx_packer.sv
// Randomized bench for udp_tx_packer against a byte-list reference model.
module tb_udp_tx_packer;

   localparam int MAXB = 1472;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic [31:0] tx_data;
   logic        tx_req;
   logic        tx_done;
   logic        busy;
   logic        trunc;

   always #5 clk = ~clk;

   udp_tx_packer #(
      .MAX_BYTES (MAXB),
      .DEPTH     (368),
      .AW        (9)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .tx_start_en (tx_start_en),
      .tx_byte_num (tx_byte_num),
      .tx_data     (tx_data),
      .tx_req      (tx_req),
      .tx_done     (tx_done),
      .busy        (busy),
      .trunc       (trunc)
   );

   int          checks = 0;
   int          errors = 0;
   int          trunc_pos;
   int          trunc_cnt;
   int          start_cnt;
   logic [15:0] start_num;
   bit          timeout;
   logic [31:0] got_q[$];

   // Expected word idx of a packet: bytes 4*idx..4*idx+3, first byte in the
   // top lane, anything at or past len reads as zero.
   function automatic logic [31:0] exp_word(input logic [7:0] b[$], input int len, input int idx);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         int p;
         p = 4 * idx + k;
         if (p < len)
            w[31-8*k -: 8] = b[p];
      end
      return w;
   endfunction

   function automatic void make_pkt(output logic [7:0] b[$], input int len);
      b.delete();
      for (int i = 0; i < len; i++)
         b.push_back(8'($urandom));
   endfunction

   // All driver tasks start and end on a falling edge.
   task automatic send_packet(input logic [7:0] b[$], input int gap);
      int  idle;
      bit  acc;
      trunc_pos = 0;
      trunc_cnt = 0;
      timeout   = 0;
      for (int i = 0; i < b.size(); i++) begin
         idle = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
         if (idle > 0) begin
            s_valid = 1'b0;
            repeat (idle) @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = b[i];
         s_last  = (i == b.size() - 1);
         acc = 1'b0;
         for (int t = 0; t < 50 && !acc; t++) begin
            acc = s_ready;
            @(negedge clk);
            if (trunc) begin
               trunc_cnt++;
               trunc_pos = i + 1;
            end
         end
         if (!acc)
            timeout = 1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_start();
      start_cnt = 0;
      start_num = '0;
      repeat (4) begin
         @(negedge clk);
         if (tx_start_en) begin
            start_cnt++;
            start_num = tx_byte_num;
         end
      end
   endtask

   task automatic read_words(input int n, input bit consec);
      got_q.delete();
      if (consec) begin
         tx_req = 1'b1;
         repeat (n) begin
            @(negedge clk);
            got_q.push_back(tx_data);
         end
         tx_req = 1'b0;
      end else begin
         repeat (n) begin
            tx_req = 1'b1;
            @(negedge clk);
            got_q.push_back(tx_data);
            tx_req = 1'b0;
            repeat ($urandom_range(2, 0)) @(negedge clk);
         end
      end
   endtask

   task automatic finish_pkt();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
      checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", tx_start_en); end
      checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL reset_byte_num: got %0d expected 0", tx_byte_num); end
      checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL reset_trunc: got %b expected 0", trunc); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_8();
      logic [7:0] p[$];
      p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_packet(p, 0);
      checks++; if (timeout) begin errors++; $display("FAIL basic_accept: got timeout expected all bytes accepted"); end
      wait_start();
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL basic_start_cnt: got %0d expected 1", start_cnt); end
      checks++; if (start_num !== 16'd8) begin errors++; $display("FAIL basic_byte_num: got %0d expected 8", start_num); end
      read_words(2, 0);
      checks++; if (got_q[0] !== 32'h01020304) begin errors++; $display("FAIL basic_word0: got %h expected 01020304", got_q[0]); end
      checks++; if (got_q[1] !== 32'h05060708) begin errors++; $display("FAIL basic_word1: got %h expected 05060708", got_q[1]); end
      checks++; if (tx_byte_num !== 16'd8) begin errors++; $display("FAIL basic_byte_num_hold: got %0d expected 8", tx_byte_num); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_send: got %b expected 1", busy); end
      finish_pkt();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fill: got %b expected 0", busy); end
   endtask

   task automatic test_pad_5();
      logic [7:0]  p[$];
      logic [31:0] e[4];
      p = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      e = '{32'hAABBCCDD, 32'hEE000000, 32'h00000000, 32'h00000000};
      send_packet(p, 1);
      wait_start();
      checks++; if (start_num !== 16'd5) begin errors++; $display("FAIL pad_byte_num: got %0d expected 5", start_num); end
      read_words(4, 1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_q[i] !== e[i]) begin errors++; $display("FAIL pad_word%0d: got %h expected %h", i, got_q[i], e[i]); end
      end
      finish_pkt();
   endtask

   task automatic test_trunc();
      logic [7:0]  p[$];
      logic [31:0] last_w;
      int          bad;
      make_pkt(p, 1500);
      send_packet(p, 0);
      checks++; if (timeout) begin errors++; $display("FAIL trunc_accept: got timeout expected 1500 bytes accepted"); end
      checks++; if (trunc_cnt != 1) begin errors++; $display("FAIL trunc_pulses: got %0d expected 1", trunc_cnt); end
      checks++; if (trunc_pos != MAXB) begin errors++; $display("FAIL trunc_pos: got %0d expected %0d", trunc_pos, MAXB); end
      wait_start();
      checks++; if (start_num !== 16'(MAXB)) begin errors++; $display("FAIL trunc_byte_num: got %0d expected %0d", start_num, MAXB); end
      read_words(MAXB / 4 + 1, 1);
      bad = 0;
      for (int i = 0; i <= MAXB / 4; i++) begin
         checks++;
         if (got_q[i] !== exp_word(p, MAXB, i)) begin
            errors++;
            if (bad < 8) $display("FAIL trunc_word%0d: got %h expected %h", i, got_q[i], exp_word(p, MAXB, i));
            bad++;
         end
      end
      last_w = {p[MAXB-4], p[MAXB-3], p[MAXB-2], p[MAXB-1]};
      checks++; if (got_q[MAXB/4-1] !== last_w) begin errors++; $display("FAIL trunc_last_word: got %h expected %h", got_q[MAXB/4-1], last_w); end
      finish_pkt();
   endtask

   task automatic test_back_to_back();
      logic [7:0] a[$];
      logic [7:0] b[$];
      make_pkt(a, 6);
      make_pkt(b, 7);
      send_packet(a, 0);
      s_valid = 1'b1;
      s_data  = b[0];
      s_last  = 1'b0;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_start: got %b expected 0", s_ready); end
      wait_start();
      checks++; if (start_num !== 16'd6) begin errors++; $display("FAIL b2b_num_a: got %0d expected 6", start_num); end
      read_words(2, 1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_q[i] !== exp_word(a, 6, i)) begin errors++; $display("FAIL b2b_a_word%0d: got %h expected %h", i, got_q[i], exp_word(a, 6, i)); end
      end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_send: got %b expected 0", s_ready); end
      finish_pkt();
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", s_ready); end
      send_packet(b, 0);
      wait_start();
      checks++; if (start_num !== 16'd7) begin errors++; $display("FAIL b2b_num_b: got %0d expected 7", start_num); end
      read_words(2, 0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_q[i] !== exp_word(b, 7, i)) begin errors++; $display("FAIL b2b_b_word%0d: got %h expected %h", i, got_q[i], exp_word(b, 7, i)); end
      end
      finish_pkt();
   endtask

   task automatic test_done_with_req();
      logic [7:0]  p[$];
      logic [7:0]  q[$];
      logic [31:0] w0;
      make_pkt(p, 8);
      send_packet(p, 0);
      wait_start();
      read_words(1, 0);
      w0 = got_q[0];
      checks++; if (w0 !== exp_word(p, 8, 0)) begin errors++; $display("FAIL dreq_word0: got %h expected %h", w0, exp_word(p, 8, 0)); end
      tx_req  = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
      tx_done = 1'b0;
      checks++; if (tx_data !== w0) begin errors++; $display("FAIL dreq_data_hold: got %h expected %h", tx_data, w0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dreq_fill: got busy %b expected 0", busy); end
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      checks++; if (tx_data !== w0) begin errors++; $display("FAIL req_outside_send: got %h expected %h", tx_data, w0); end
      finish_pkt();
      checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL done_outside_send: got busy %b ready %b expected 0 1", busy, s_ready); end
      make_pkt(q, 4);
      send_packet(q, 0);
      wait_start();
      checks++; if (start_num !== 16'd4) begin errors++; $display("FAIL dreq_num_next: got %0d expected 4", start_num); end
      read_words(1, 0);
      checks++; if (got_q[0] !== exp_word(q, 4, 0)) begin errors++; $display("FAIL dreq_next_word0: got %h expected %h", got_q[0], exp_word(q, 4, 0)); end
      finish_pkt();
   endtask

   task automatic test_reset_mid_send();
      logic [7:0] p[$];
      logic [7:0] q[$];
      make_pkt(p, 12);
      send_packet(p, 0);
      wait_start();
      read_words(1, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_s_ready: got %b expected 1", s_ready); end
      checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b expected 0", tx_start_en); end
      checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL rmid_byte_num: got %0d expected 0", tx_byte_num); end
      checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL rmid_tx_data: got %h expected 0", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL rmid_trunc: got %b expected 0", trunc); end
      make_pkt(q, 4);
      send_packet(q, 0);
      wait_start();
      checks++; if (start_num !== 16'd4) begin errors++; $display("FAIL rmid_num: got %0d expected 4", start_num); end
      read_words(2, 1);
      checks++; if (got_q[0] !== exp_word(q, 4, 0)) begin errors++; $display("FAIL rmid_word0: got %h expected %h", got_q[0], exp_word(q, 4, 0)); end
      checks++; if (got_q[1] !== 32'd0) begin errors++; $display("FAIL rmid_pad: got %h expected 0", got_q[1]); end
      finish_pkt();
   endtask

   task automatic test_random();
      logic [7:0] p[$];
      int         len;
      int         n;
      for (int it = 0; it < 10; it++) begin
         len = int'($urandom_range(60, 1));
         make_pkt(p, len);
         send_packet(p, 2);
         checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_accept: got timeout expected accepted", it); end
         wait_start();
         checks++; if (start_cnt != 1 || start_num !== 16'(len)) begin errors++; $display("FAIL rnd%0d_start: got cnt %0d num %0d expected 1 %0d", it, start_cnt, start_num, len); end
         n = (len + 3) / 4 + int'($urandom_range(2, 0));
         read_words(n, 1'($urandom_range(1, 0)));
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_word(p, len, i)) begin errors++; $display("FAIL rnd%0d_word%0d: got %h expected %h", it, i, got_q[i], exp_word(p, len, i)); end
         end
         finish_pkt();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      tx_req  = 1'b0;
      tx_done = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_8();
      test_pad_5();
      test_trunc();
      test_back_to_back();
      test_done_with_req();
      test_reset_mid_send();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
